decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/decode_pkg.sv | 48 ++++
 rtl/decode_if.sv | 10 +
 rtl/decode_imm_gen.sv | 23 ++
 rtl/decode.sv | 137 +++++++++++++
 tb/tb_decode.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcode constants, opclass/format/state enums for decode
package decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Encoding 0 is reserved for the reset/no-result value, so ILLEGAL is non-zero.
  typedef enum logic [3:0] {
    OC_NONE    = 4'd0,
    OC_LUI     = 4'd1,
    OC_AUIPC   = 4'd2,
    OC_JAL     = 4'd3,
    OC_JALR    = 4'd4,
    OC_BRANCH  = 4'd5,
    OC_LOAD    = 4'd6,
    OC_STORE   = 4'd7,
    OC_OPIMM   = 4'd8,
    OC_OP      = 4'd9,
    OC_MISC    = 4'd10,
    OC_ILLEGAL = 4'd11
  } opclass_e;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_READ,
    S_DONE
  } state_e;

endpackage

// File: rtl/decode_if.sv
// rtl/decode_if.sv - register-file read port between decode and the register file
interface decode_if;
  logic [4:0]  reg_addr1;
  logic [4:0]  reg_addr2;
  logic [31:0] reg_data1;
  logic [31:0] reg_data2;

  modport master (output reg_addr1, output reg_addr2, input reg_data1, input reg_data2);
  modport slave  (input reg_addr1, input reg_addr2, output reg_data1, output reg_data2);
endinterface

// File: rtl/decode_imm_gen.sv
// rtl/decode_imm_gen.sv - combinational RV32I immediate generator
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:7] instr,
  input  fmt_e        fmt,
  output logic [31:0] imm
);

  // Assemble the sign-extended immediate for the instruction format; R-type yields 0.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// rtl/decode.sv - three-edge instruction decode stage with register-file operand read
module decode
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        enabled,
  input  logic [31:0] pc,
  input  logic [31:0] instr_raw,
  decode_if.master    rf,
  output logic        completed,
  output logic [31:0] pc_n,
  output opclass_e    opclass,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val,
  output logic        illegal
);

  state_e      state;
  state_e      state_nx;
  logic [31:0] instr_q;
  logic        done;

  opclass_e    dec_class;
  fmt_e        dec_fmt;
  logic        use_rd;
  logic        use_rs1;
  logic        use_rs2;
  logic [31:0] gen_imm;

  imm_gen u_imm_gen (
    .instr (instr_q[31:7]),
    .fmt   (dec_fmt),
    .imm   (gen_imm)
  );

  // Classify the latched word: opclass, immediate format and which register fields are live.
  always_comb begin
    dec_class = OC_ILLEGAL;
    dec_fmt   = FMT_R;
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    if (instr_q[1:0] == 2'b11) begin
      case (instr_q[6:0])
        OPC_LUI:    begin dec_class = OC_LUI;    dec_fmt = FMT_U; use_rd = 1'b1; end
        OPC_AUIPC:  begin dec_class = OC_AUIPC;  dec_fmt = FMT_U; use_rd = 1'b1; end
        OPC_JAL:    begin dec_class = OC_JAL;    dec_fmt = FMT_J; use_rd = 1'b1; end
        OPC_JALR:   begin dec_class = OC_JALR;   dec_fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1; end
        OPC_BRANCH: begin dec_class = OC_BRANCH; dec_fmt = FMT_B; use_rs1 = 1'b1; use_rs2 = 1'b1; end
        OPC_LOAD:   begin dec_class = OC_LOAD;   dec_fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1; end
        OPC_STORE:  begin dec_class = OC_STORE;  dec_fmt = FMT_S; use_rs1 = 1'b1; use_rs2 = 1'b1; end
        OPC_OPIMM:  begin dec_class = OC_OPIMM;  dec_fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1; end
        OPC_OP:     begin dec_class = OC_OP;     dec_fmt = FMT_R; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
        OPC_MISC_MEM, OPC_SYSTEM: begin
          dec_class = OC_MISC; dec_fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rstn) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next state: a start strobe restarts from any state, otherwise walk DECODE -> READ -> DONE.
  always_comb begin
    state_nx = state;
    if (enabled) begin
      state_nx = S_DECODE;
    end else begin
      case (state)
        S_DECODE: state_nx = S_READ;
        S_READ:   state_nx = S_DONE;
        default:  state_nx = state;
      endcase
    end
  end

  // Datapath: latch on start, register decoded fields in DECODE, capture operands in READ.
  always_ff @(posedge clk) begin
    if (rstn) begin
      instr_q      <= '0;
      done         <= 1'b0;
      pc_n         <= '0;
      opclass      <= OC_NONE;
      rd           <= '0;
      rs1          <= '0;
      rs2          <= '0;
      funct3       <= '0;
      funct7       <= '0;
      imm          <= '0;
      rs1_val      <= '0;
      rs2_val      <= '0;
      illegal      <= 1'b0;
      rf.reg_addr1 <= '0;
      rf.reg_addr2 <= '0;
    end else if (enabled) begin
      pc_n    <= pc;
      instr_q <= instr_raw;
      done    <= 1'b0;
    end else begin
      case (state)
        S_DECODE: begin
          opclass      <= dec_class;
          rd           <= use_rd  ? instr_q[11:7]  : 5'd0;
          rs1          <= use_rs1 ? instr_q[19:15] : 5'd0;
          rs2          <= use_rs2 ? instr_q[24:20] : 5'd0;
          rf.reg_addr1 <= use_rs1 ? instr_q[19:15] : 5'd0;
          rf.reg_addr2 <= use_rs2 ? instr_q[24:20] : 5'd0;
          funct3       <= instr_q[14:12];
          funct7       <= instr_q[31:25];
          imm          <= gen_imm;
          illegal      <= (dec_class == OC_ILLEGAL);
        end
        S_READ: begin
          rs1_val <= (rs1 == 5'd0) ? 32'd0 : rf.reg_data1;
          rs2_val <= (rs2 == 5'd0) ? 32'd0 : rf.reg_data2;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign completed = done & ~enabled;

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - randomized self-checking bench for decode against a behavioural model
module tb_decode;
  import decode_pkg::*;

  typedef struct {
    logic [3:0]  oc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        enabled = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr_raw = '0;
  logic        completed;
  logic [31:0] pc_n;
  opclass_e    opclass;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm, rs1_val, rs2_val;
  logic        illegal;

  logic [31:0] regs [32];
  logic [6:0]  ops [11];

  int errors = 0;
  int checks = 0;

  decode_if rf ();

  assign rf.reg_data1 = regs[rf.reg_addr1];
  assign rf.reg_data2 = regs[rf.reg_addr2];

  decode dut (
    .clk       (clk),
    .rstn      (rstn),
    .enabled   (enabled),
    .pc        (pc),
    .instr_raw (instr_raw),
    .rf        (rf),
    .completed (completed),
    .pc_n      (pc_n),
    .opclass   (opclass),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Reference decode straight from the RV32I field rules.
  function automatic exp_t model_of(input logic [31:0] w, input logic [31:0] p);
    exp_t e;
    byte f;
    logic signed [31:0] sw;
    logic [31:0] ih;
    e = '{oc: 4'd0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, f3: w[14:12], f7: w[31:25],
          imm: 32'd0, v1: 32'd0, v2: 32'd0, ill: 1'b0, pc: p};
    f = "X";
    if (w[1:0] == 2'b11) begin
      case (w[6:0])
        7'b0110111: begin e.oc = OC_LUI;    f = "U"; end
        7'b0010111: begin e.oc = OC_AUIPC;  f = "U"; end
        7'b1101111: begin e.oc = OC_JAL;    f = "J"; end
        7'b1100111: begin e.oc = OC_JALR;   f = "I"; end
        7'b1100011: begin e.oc = OC_BRANCH; f = "B"; end
        7'b0000011: begin e.oc = OC_LOAD;   f = "I"; end
        7'b0100011: begin e.oc = OC_STORE;  f = "S"; end
        7'b0010011: begin e.oc = OC_OPIMM;  f = "I"; end
        7'b0110011: begin e.oc = OC_OP;     f = "R"; end
        7'b0001111: begin e.oc = OC_MISC;   f = "I"; end
        7'b1110011: begin e.oc = OC_MISC;   f = "I"; end
        default: f = "X";
      endcase
    end
    if (f == "X") begin
      e.oc  = OC_ILLEGAL;
      e.ill = 1'b1;
      return e;
    end
    if (f != "S" && f != "B") e.rd = w[11:7];
    if (f == "I" || f == "S" || f == "B" || f == "R") e.rs1 = w[19:15];
    if (f == "S" || f == "B" || f == "R") e.rs2 = w[24:20];
    sw = w;
    ih = sw >>> 20;
    case (f)
      "I": e.imm = ih;
      "S": e.imm = {ih[31:5], w[11:7]};
      "B": e.imm = (w[31] ? 32'hFFFFF000 : 32'h0) | (32'(w[7]) << 11)
                 | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      "U": e.imm = w & 32'hFFFFF000;
      "J": e.imm = (w[31] ? 32'hFFF00000 : 32'h0) | (w & 32'h000FF000)
                 | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      default: e.imm = 32'd0;
    endcase
    e.v1 = (e.rs1 == 5'd0) ? 32'd0 : regs[e.rs1];
    e.v2 = (e.rs2 == 5'd0) ? 32'd0 : regs[e.rs2];
    return e;
  endfunction

  // Model timeline: result appears two edges after the edge that sampled enabled.
  exp_t cur, pend;
  bit   started = 0;
  bit   clean = 0;
  bit   have_res = 0;
  bit   busy = 0;
  int   cnt = 0;

  always @(posedge clk) begin
    if (rstn) begin
      started  = 1;
      clean    = 1;
      have_res = 0;
      busy     = 0;
      cur      = '{oc: 4'd0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, f7: 7'd0,
                   imm: 32'd0, v1: 32'd0, v2: 32'd0, ill: 1'b0, pc: 32'd0};
    end else if (enabled) begin
      pend     = model_of(instr_raw, pc);
      busy     = 1;
      cnt      = 0;
      have_res = 0;
      clean    = 0;
    end else if (busy) begin
      cnt++;
      if (cnt == 2) begin
        have_res = 1;
        busy     = 0;
        cur      = pend;
      end
    end
  end

  // Compare the DUT with the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("completed", {31'd0, completed}, {31'd0, have_res & ~enabled});
      if (have_res || clean) begin
        chk("opclass", {28'd0, opclass}, {28'd0, cur.oc});
        chk("rd", {27'd0, rd}, {27'd0, cur.rd});
        chk("rs1", {27'd0, rs1}, {27'd0, cur.rs1});
        chk("rs2", {27'd0, rs2}, {27'd0, cur.rs2});
        chk("reg_addr1", {27'd0, rf.reg_addr1}, {27'd0, cur.rs1});
        chk("reg_addr2", {27'd0, rf.reg_addr2}, {27'd0, cur.rs2});
        chk("funct3", {29'd0, funct3}, {29'd0, cur.f3});
        chk("funct7", {25'd0, funct7}, {25'd0, cur.f7});
        chk("imm", imm, cur.imm);
        chk("rs1_val", rs1_val, cur.v1);
        chk("rs2_val", rs2_val, cur.v2);
        chk("illegal", {31'd0, illegal}, {31'd0, cur.ill});
        chk("pc_n", pc_n, cur.pc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start(input logic [31:0] w, input logic [31:0] p);
    instr_raw = w;
    pc        = p;
    enabled   = 1'b1;
    step(1);
    enabled   = 1'b0;
    instr_raw = $urandom;
    pc        = $urandom;
  endtask

  task automatic run_lat(input logic [31:0] w, input logic [31:0] p);
    start(w, p);
    step(1);
    chk("lat_edge2", {31'd0, completed}, 32'd0);
    step(1);
    chk("lat_edge3", {31'd0, completed}, 32'd1);
  endtask

  task automatic rand_regs();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 13);
    if (k < 11)       w[6:0] = ops[k];
    else if (k == 11) w[1:0] = 2'($urandom_range(0, 2));
    return w;
  endfunction

  initial begin
    exp_t e;
    int mode;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
            7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};
    rand_regs();

    // Pin the model on hand-decoded words.
    regs[1] = 32'h10;
    e = model_of(32'hFFF08293, 32'h0);
    chk("model_addi_imm", e.imm, 32'hFFFFFFFF);
    chk("model_addi_rd", {27'd0, e.rd}, 32'd5);
    chk("model_addi_v1", e.v1, 32'h10);
    e = model_of(32'h0021A423, 32'h0);
    chk("model_sw_imm", e.imm, 32'd8);
    chk("model_sw_rd", {27'd0, e.rd}, 32'd0);
    e = model_of(32'hFE000EE3, 32'h0);
    chk("model_beq_imm", e.imm, 32'hFFFFFFFC);
    e = model_of(32'h12345537, 32'h0);
    chk("model_lui_imm", e.imm, 32'h12345000);

    // Reset state.
    step(2);
    rstn = 1'b0;
    chk("rst_opclass", {28'd0, opclass}, 32'd0);
    chk("rst_completed", {31'd0, completed}, 32'd0);
    chk("rst_pc_n", pc_n, 32'd0);

    // addi x5,x1,-1
    regs[1] = 32'h10;
    run_lat(32'hFFF08293, 32'h1000);
    chk("addi_opclass", {28'd0, opclass}, {28'd0, OC_OPIMM});
    chk("addi_rd", {27'd0, rd}, 32'd5);
    chk("addi_rs1", {27'd0, rs1}, 32'd1);
    chk("addi_rs2", {27'd0, rs2}, 32'd0);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    chk("addi_rs1_val", rs1_val, 32'h10);
    chk("addi_pc_n", pc_n, 32'h1000);
    step(2);
    chk("addi_hold", {31'd0, completed}, 32'd1);

    // sw x2,8(x3)
    regs[3] = 32'h100;
    regs[2] = 32'hAB;
    run_lat(32'h0021A423, 32'h1004);
    chk("sw_opclass", {28'd0, opclass}, {28'd0, OC_STORE});
    chk("sw_rd", {27'd0, rd}, 32'd0);
    chk("sw_imm", imm, 32'd8);
    chk("sw_rs1_val", rs1_val, 32'h100);
    chk("sw_rs2_val", rs2_val, 32'hAB);

    // beq x0,x0,-4 with garbage on the read ports
    for (int i = 0; i < 32; i++) regs[i] = 32'hDEADBEEF;
    run_lat(32'hFE000EE3, 32'h1008);
    chk("beq_opclass", {28'd0, opclass}, {28'd0, OC_BRANCH});
    chk("beq_imm", imm, 32'hFFFFFFFC);
    chk("beq_rs1_val", rs1_val, 32'd0);
    chk("beq_rs2_val", rs2_val, 32'd0);

    // lui x10,0x12345 then an all-zero word
    run_lat(32'h12345537, 32'h100C);
    chk("lui_opclass", {28'd0, opclass}, {28'd0, OC_LUI});
    chk("lui_rd", {27'd0, rd}, 32'd10);
    chk("lui_imm", imm, 32'h12345000);
    run_lat(32'h00000000, 32'h1010);
    chk("zero_opclass", {28'd0, opclass}, {28'd0, OC_ILLEGAL});
    chk("zero_illegal", {31'd0, illegal}, 32'd1);
    chk("zero_rd", {27'd0, rd}, 32'd0);

    // Re-pulse during READ: only the second word completes.
    rand_regs();
    start(32'h12345537, 32'h2000);
    step(1);
    start(32'h0021A423, 32'h2004);
    chk("abort_no_pulse", {31'd0, completed}, 32'd0);
    step(1);
    chk("abort_lat2", {31'd0, completed}, 32'd0);
    step(1);
    chk("abort_lat3", {31'd0, completed}, 32'd1);
    chk("abort_opclass", {28'd0, opclass}, {28'd0, OC_STORE});
    chk("abort_pc_n", pc_n, 32'h2004);

    // Reset while in DECODE discards everything.
    start(32'hFFF08293, 32'h3000);
    rstn = 1'b1;
    step(1);
    rstn = 1'b0;
    chk("rstmid_opclass", {28'd0, opclass}, 32'd0);
    chk("rstmid_imm", imm, 32'd0);
    chk("rstmid_pc_n", pc_n, 32'd0);
    chk("rstmid_completed", {31'd0, completed}, 32'd0);
    step(3);
    chk("rstmid_stays_idle", {31'd0, completed}, 32'd0);

    // Randomized traffic: normal runs, aborts and mid-operation resets.
    for (int t = 0; t < 300; t++) begin
      rand_regs();
      mode = $urandom_range(0, 9);
      start(rand_instr(), $urandom);
      if (mode < 7) begin
        step(2 + $urandom_range(0, 2));
      end else if (mode < 9) begin
        step($urandom_range(0, 1));
        rand_regs();
        start(rand_instr(), $urandom);
        step(2 + $urandom_range(0, 1));
      end else begin
        step($urandom_range(0, 1));
        rstn = 1'b1;
        step(1);
        rstn = 1'b0;
        step(1);
      end
    end

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
